soc_uart: RTL and testbench

- Memory-mapped UART peripheral on the SoC's single-master CPU bus (addr/rw/din/dout/valid/ready), alongside the BRAM controller.
- Drives the board TX pin and samples the RX pin.
- Exposes a DATA register and a STATUS register to the CPU, with a TX holding register and a 4-entry RX FIFO.
- Frame format fixed at 8N1.

---
 rtl/soc_uart.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_soc_uart.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_uart.sv
// soc_uart: memory-mapped 8N1 UART peripheral.
// DATA register at addr[2]=0, STATUS at addr[2]=1, addr[3]=1 is an unmapped hole.
// One-byte TX holding register in front of the shifter, small RX FIFO behind the receiver.
module soc_uart #(
    parameter int clks_per_bit = 104,
    parameter int rx_fifo_aw   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic        rw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        valid,
    output logic        ready,
    input  logic        rx,
    output logic        tx
);
    localparam int CW    = $clog2(clks_per_bit);
    localparam int DEPTH = 1 << rx_fifo_aw;

    localparam logic [CW-1:0]       BIT_LAST  = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0]       HALF_LAST = CW'(clks_per_bit / 2 - 1);
    localparam logic [rx_fifo_aw:0] FIFO_FULL = (rx_fifo_aw + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus response
    logic                  ready_q;
    logic [31:0]           dout_q, dout_d;
    // Transmitter
    logic [1:0]            tx_state_q, tx_state_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [2:0]            tx_bit_q, tx_bit_d;
    logic [7:0]            tx_sh_q, tx_sh_d;
    logic                  tx_q, tx_d;
    logic [7:0]            hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  tx_load;
    // Receiver
    logic                  rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]            rx_state_q, rx_state_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [2:0]            rx_bit_q, rx_bit_d;
    logic [7:0]            rx_sh_q, rx_sh_d;
    logic                  rx_push, rx_ferr;
    // RX FIFO and sticky flags
    logic [7:0]            fifo_mem [DEPTH];
    logic [rx_fifo_aw-1:0] wptr_q, rptr_q;
    logic [rx_fifo_aw:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  ferr_q, ferr_d;
    logic                  fifo_empty, fifo_full, push_ok, pop;
    // Request decode
    logic                  req, data_wr, stall, accept, wr_hold, rd_data, rd_stat;
    logic                  unused_bits;

    assign unused_bits = ^{din[31:8], addr[1:0]};
    assign ready       = ready_q;
    assign dout        = dout_q;
    assign tx          = tx_q;

    // Request decode, read mux, FIFO occupancy and sticky flag update
    always_comb begin
        req        = valid && !ready_q;
        data_wr    = req && rw && !addr[3] && !addr[2];
        stall      = data_wr && hold_full_q;
        accept     = req && !stall;
        wr_hold    = accept && data_wr;
        rd_data    = accept && !rw && !addr[3] && !addr[2];
        rd_stat    = accept && !rw && !addr[3] && addr[2];
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FIFO_FULL);
        pop        = rd_data && !fifo_empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push_ok    = rx_push && (!fifo_full || pop);
        count_d    = count_q + (rx_fifo_aw + 1)'(push_ok) - (rx_fifo_aw + 1)'(pop);

        dout_d = '0;
        if (pop) begin
            dout_d = {24'd0, fifo_mem[rptr_q]};
        end else if (rd_stat) begin
            dout_d = {28'd0, ferr_q, overrun_q, !fifo_empty, hold_full_q};
        end

        // a flag raised in the same cycle as the clearing STATUS read stays set
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        if (rd_stat) begin
            overrun_d = 1'b0;
            ferr_d    = 1'b0;
        end
        if (rx_push && !push_ok) overrun_d = 1'b1;
        if (rx_ferr)             ferr_d    = 1'b1;
    end

    // Bus response: one-cycle ready pulse, read data only while ready is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            ready_q <= accept;
            dout_q  <= dout_d;
        end
    end

    // TX next state: holding register hand-off, bit timing and shifting
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_sh_d     = tx_sh_q;
        tx_d        = tx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_load     = 1'b0;
        case (tx_state_q)
            ST_IDLE: tx_load = hold_full_q;
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (hold_full_q) tx_load = 1'b1;
                    else             tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // loading at the end of STOP chains straight into the next START bit
        if (tx_load) begin
            tx_sh_d     = hold_q;
            hold_full_d = 1'b0;
            tx_state_d  = ST_START;
            tx_cnt_d    = '0;
            tx_d        = 1'b0;
        end
        if (wr_hold) begin
            hold_d      = din[7:0];
            hold_full_d = 1'b1;
        end
    end

    // TX state registers; the line idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            tx_q        <= 1'b1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // RX next state: start-bit qualification at mid-bit, then one sample per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    rx_push    = rx_s2_q;
                    rx_ferr    = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX synchroniser, edge-detect history and receiver state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // RX FIFO storage; only slots below the count are ever read, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr_q] <= rx_sh_q;
    end

    // RX FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

endmodule

// File: tb/tb_soc_uart.sv
// tb_soc_uart: directed self-checking bench for soc_uart with clks_per_bit=4.
`timescale 1ns/1ps
module tb_soc_uart;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset, rw, valid, rx, tx, ready;
    logic [3:0]  addr;
    logic [31:0] din, dout;

    int checks = 0;
    int errors = 0;

    logic txs [200];
    logic rdy [200];

    typedef struct {
        logic [3:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] exp_dout;
    } vec_t;

    always #5 clk = ~clk;

    soc_uart #(.clks_per_bit(CPB), .rx_fifo_aw(2)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .rw    (rw),
        .din   (din),
        .dout  (dout),
        .valid (valid),
        .ready (ready),
        .rx    (rx),
        .tx    (tx)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus transaction; lat = number of clock edges until ready is seen.
    task automatic bus(input logic [3:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        if (ready) begin
            @(posedge clk);
            #1;
        end
        addr = a; rw = w; din = d; valid = 1'b1;
        lat = 0; rd = '0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = n;
                rd  = dout;
                break;
            end
        end
        valid = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: addr 0x%0h got no ready, required ready within 200 cycles", a);
        end
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txs[i] = tx;
            rdy[i] = ready;
        end
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] f;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)        f[i] = 1'b0;
            else if (i >= 36) f[i] = 1'b1;
            else              f[i] = b[(i - 4) / 4];
        end
        return f;
    endfunction

    // Locate the first start bit, compare each frame sample-for-sample, then require idle.
    task automatic check_tx(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int nb, input int n, output int s);
        logic [7:0]  bytes [3];
        logic [39:0] act;
        logic        idle_ok;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        s = -1;
        for (int i = 0; i < 8; i++) if (s < 0 && txs[i] == 1'b0) s = i;
        chk({name, "_start_found"}, 64'(s >= 0), 64'd1);
        if (s >= 0) begin
            for (int f = 0; f < nb; f++) begin
                for (int j = 0; j < 40; j++) act[j] = txs[s + 40 * f + j];
                chk($sformatf("%s_frame%0d", name, f), 64'(act), 64'(frame_bits(bytes[f])));
            end
            idle_ok = 1'b1;
            for (int i = s + 40 * nb; i < n; i++) if (txs[i] !== 1'b1) idle_ok = 1'b0;
            chk({name, "_idle_after"}, 64'(idle_ok), 64'd1);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopb;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [7];
        logic [31:0] rd;
        logic        idle_ok;
        int          lat;
        int          s;

        vt[0] = '{4'h4, 1'b0, 32'h0,  32'h0};  // STATUS after reset
        vt[1] = '{4'h0, 1'b0, 32'h0,  32'h0};  // DATA read, FIFO empty
        vt[2] = '{4'h4, 1'b1, 32'hFF, 32'h0};  // STATUS write ignored
        vt[3] = '{4'h8, 1'b0, 32'h0,  32'h0};  // hole read
        vt[4] = '{4'hC, 1'b1, 32'h41, 32'h0};  // hole write ignored
        vt[5] = '{4'hC, 1'b0, 32'h0,  32'h0};  // hole read
        vt[6] = '{4'h4, 1'b0, 32'h0,  32'h0};  // STATUS unchanged

        reset = 1'b1; rx = 1'b1; valid = 1'b0; addr = '0; rw = 1'b0; din = '0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 0);
        chk("rst_dout", dout, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            bus(vt[i].a, vt[i].w, vt[i].d, rd, lat);
            chk($sformatf("vec%0d_dout", i), rd, vt[i].exp_dout);
            chk($sformatf("vec%0d_lat", i), lat, 1);
        end
        idle_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) idle_ok = 1'b0;
        end
        chk("tx_idle_after_ignored_writes", idle_ok, 1);

        // Reset in the middle of a frame, with a byte held and a ready pulse in flight
        bus(4'h0, 1'b1, 32'h0, rd, lat);
        bus(4'h0, 1'b1, 32'h0, rd, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_tx_low", tx, 0);
        addr = 4'h4; rw = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_ready", ready, 1);
        chk("pre_reset_status", dout, 32'h1);
        valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_ready", ready, 0);
        chk("async_reset_dout", dout, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("status_after_mid_reset", rd, 32'h0);

        // Single byte 0xA5
        fork
            record(60);
            begin
                bus(4'h0, 1'b1, 32'hA5, rd, lat);
                chk("a5_write_lat", lat, 1);
                bus(4'h4, 1'b0, 32'h0, rd, lat);
                chk("a5_status_after_load", rd, 32'h0);
            end
        join
        check_tx("a5", 8'hA5, 8'h00, 8'h00, 1, 60, s);

        // Back-to-back bytes; the third write stalls while 0x0F sits in the holding register
        fork
            record(150);
            begin
                bus(4'h0, 1'b1, 32'h55, rd, lat);
                chk("b_write55_lat", lat, 1);
                bus(4'h0, 1'b1, 32'h0F, rd, lat);
                chk("b_write0f_lat", lat, 1);
                bus(4'h4, 1'b0, 32'h0, rd, lat);
                chk("b_status_hold_full", rd, 32'h1);
                bus(4'h0, 1'b1, 32'hF0, rd, lat);
                chk("b_writef0_stalled", 64'(lat > 2), 64'd1);
            end
        join
        check_tx("b", 8'h55, 8'h0F, 8'hF0, 3, 150, s);
        if (s >= 0) chk("b_ready_after_hold_clears", {rdy[s + 40], rdy[s + 41]}, 2'b01);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("b_status_done", rd, 32'h0);

        // Receive 0x3C
        send_rx(8'h3C, 1'b1);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("rx3c_status", rd, 32'h2);
        bus(4'h0, 1'b0, 32'h0, rd, lat);
        chk("rx3c_data", rd, 32'h3C);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("rx3c_status_empty", rd, 32'h0);

        // One-cycle glitch must not produce a byte
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("glitch_status", rd, 32'h0);

        // Five bytes into a four-entry FIFO
        for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("overrun_status", rd, 32'h6);
        for (int b = 1; b <= 4; b++) begin
            bus(4'h0, 1'b0, 32'h0, rd, lat);
            chk($sformatf("fifo_read%0d", b), rd, 32'(b));
        end
        bus(4'h0, 1'b0, 32'h0, rd, lat);
        chk("fifo_read_empty", rd, 32'h0);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("overrun_cleared", rd, 32'h0);

        // Framing error: stop bit sampled low
        send_rx(8'hA7, 1'b0);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("ferr_status", rd, 32'h8);
        bus(4'h0, 1'b0, 32'h0, rd, lat);
        chk("ferr_fifo_empty", rd, 32'h0);
        bus(4'h8, 1'b0, 32'h0, rd, lat);
        chk("hole_data_read", rd, 32'h0);
        chk("hole_data_lat", lat, 1);
        bus(4'hC, 1'b0, 32'h0, rd, lat);
        chk("hole_status_read", rd, 32'h0);
        chk("hole_status_lat", lat, 1);
        bus(4'h4, 1'b0, 32'h0, rd, lat);
        chk("ferr_cleared", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
